// File: rtl/chacha_pkg.sv
// chacha_pkg: shared constants, state encoding and word-index helpers for the ChaCha block core.
package chacha_pkg;
  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;
  localparam int WORDS = 16;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  typedef logic [WORDS-1:0][31:0] words_t;
  // Word index of row/lane in the 4x4 state; diagonal rounds shift each row left by its row number.
  function automatic logic [3:0] idx(input logic [1:0] row, input logic [1:0] col, input logic diag);
    return {row, 2'(col + (diag ? row : 2'd0))};
  endfunction
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction
endpackage

// File: rtl/chacha_quarterround.sv
// chacha_quarterround: combinational ChaCha quarter round on four 32-bit words.
module chacha_quarterround
  import chacha_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] ya,
  output logic [31:0] yb,
  output logic [31:0] yc,
  output logic [31:0] yd
);
  logic [31:0] a1, b1, c1, d1;
  assign a1 = a + b;
  assign d1 = rotl(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl(b ^ c1, 12);
  assign ya = a1 + b1;
  assign yd = rotl(d1 ^ ya, 8);
  assign yc = c1 + yd;
  assign yb = rotl(b1 ^ yc, 7);
endmodule

// File: rtl/chacha_block_core.sv
// chacha_block_core: iterative ChaCha block function, one round per cycle with four parallel quarter rounds.
// Optional CHACHA_CTR_AUTOINC_EN adds next_blk to chain blocks with an incremented counter.
module chacha_block_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
`ifdef CHACHA_CTR_AUTOINC_EN
  input  logic         next_blk,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic         busy
);
  state_t st;
  logic [4:0] rnd;
  words_t work, saved, nxt, sum, init;
  logic [3:0][31:0] qa, qb, qc, qd, ra, rb, rc, rd;
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
  assign busy = st != IDLE;
  assign init = {nonce, counter, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      qa[i] = work[idx(2'd0, i[1:0], rnd[0])];
      qb[i] = work[idx(2'd1, i[1:0], rnd[0])];
      qc[i] = work[idx(2'd2, i[1:0], rnd[0])];
      qd[i] = work[idx(2'd3, i[1:0], rnd[0])];
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_quarterround u_qr (
      .a(qa[g]), .b(qb[g]), .c(qc[g]), .d(qd[g]),
      .ya(ra[g]), .yb(rb[g]), .yc(rc[g]), .yd(rd[g])
    );
  end
  always_comb begin
    nxt = work;
    for (int i = 0; i < 4; i++) begin
      nxt[idx(2'd0, i[1:0], rnd[0])] = ra[i];
      nxt[idx(2'd1, i[1:0], rnd[0])] = rb[i];
      nxt[idx(2'd2, i[1:0], rnd[0])] = rc[i];
      nxt[idx(2'd3, i[1:0], rnd[0])] = rd[i];
    end
    for (int i = 0; i < WORDS; i++) sum[i] = work[i] + saved[i];
  end
`ifdef CHACHA_CTR_AUTOINC_EN
  words_t bumped;
  always_comb begin
    bumped = saved;
    bumped[12] = saved[12] + 32'd1;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      rnd <= '0;
      work <= '0;
      saved <= '0;
      keystream <= '0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          work <= init;
          saved <= init;
          rnd <= '0;
          st <= ROUND;
        end
        ROUND: begin
          work <= nxt;
          rnd <= rnd + 5'd1;
          st <= rnd == 5'(ROUNDS - 1) ? FINAL : ROUND;
        end
        FINAL: begin
          keystream <= sum;
          st <= DONE;
        end
        default: if (out_ready) begin
`ifdef CHACHA_CTR_AUTOINC_EN
          if (next_blk) begin
            work <= bumped;
            saved <= bumped;
            rnd <= '0;
            st <= ROUND;
          end else st <= IDLE;
`else
          st <= IDLE;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_chacha_block_core.sv
// tb_chacha_block_core: scoreboard bench for chacha_block_core (20-round and 8-round instances).
module tb_chacha_block_core;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, in_ready, out_valid, busy;
  logic [255:0] key = '0;
  logic [95:0] nonce = '0;
  logic [31:0] counter = '0;
  logic [511:0] keystream;
  logic in_valid8 = 0, in_ready8, out_valid8, busy8;
  logic [511:0] ks8;
`ifdef CHACHA_CTR_AUTOINC_EN
  logic next_blk = 0;
`endif
  int checks = 0, errors = 0;
  logic [511:0] q[$];
  localparam logic [511:0] RFC = {
    32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
    32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
    32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
    32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

  always #5 clk = ~clk;

  chacha_block_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .nonce(nonce), .counter(counter),
`ifdef CHACHA_CTR_AUTOINC_EN
    .next_blk(next_blk),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .keystream(keystream), .busy(busy));

  chacha_block_core #(.ROUNDS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .key(key), .nonce(nonce), .counter(counter),
`ifdef CHACHA_CTR_AUTOINC_EN
    .next_blk(1'b0),
`endif
    .out_valid(out_valid8), .out_ready(1'b1), .keystream(ks8), .busy(busy8));

  function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
    a += b; d ^= a; d = {d[15:0], d[31:16]};
    c += d; b ^= c; b = {b[19:0], b[31:20]};
    a += b; d ^= a; d = {d[23:0], d[31:24]};
    c += d; b ^= c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c, input int rounds);
    logic [31:0] x[16], s[16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i+:32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i+:32];
    x = s;
    for (int j = 0; j < rounds / 2; j++) begin
      {x[0], x[4], x[8], x[12]} = qr(x[0], x[4], x[8], x[12]);
      {x[1], x[5], x[9], x[13]} = qr(x[1], x[5], x[9], x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8], x[13]} = qr(x[2], x[7], x[8], x[13]);
      {x[3], x[4], x[9], x[14]} = qr(x[3], x[4], x[9], x[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i+:32] = x[i] + s[i];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i+:32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    key = k; nonce = n; counter = c; in_valid = 1;
    q.push_back(ref_block(k, n, c, 20));
    tick();
    in_valid = 0;
  endtask

  task automatic collect(input int exp_lat, input string name, output logic [511:0] got);
    int lat = 0;
    logic [511:0] exp;
    while (!out_valid && lat < 200) begin tick(); lat++; end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    end
    got = keystream;
    exp = q.size() > 0 ? q.pop_front() : '0;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s block got %h want %h", name, got, exp);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    checks++;
    if ({in_ready, out_valid, busy, in_ready8, busy8} !== 5'b10010) begin
      errors++;
      $display("FAIL reset_flags got %b want 10010", {in_ready, out_valid, busy, in_ready8, busy8});
    end
    checks++;
    if (keystream !== '0) begin errors++; $display("FAIL reset_keystream got %h want 0", keystream); end
  endtask

  task automatic test_rfc();
    logic [255:0] k;
    logic [511:0] got;
    for (int i = 0; i < 32; i++) k[8*i+:8] = 8'(i);
    send(k, {32'h0, 32'h4a000000, 32'h09000000}, 32'd1);
    collect(21, "rfc", got);
    checks++;
    if (got[31:0] !== 32'he4e7f110) begin errors++; $display("FAIL rfc_w0 got %h want e4e7f110", got[31:0]); end
    checks++;
    if (got[63:32] !== 32'h15593bd1) begin errors++; $display("FAIL rfc_w1 got %h want 15593bd1", got[63:32]); end
    checks++;
    if (got !== RFC) begin errors++; $display("FAIL rfc_full got %h want %h", got, RFC); end
  endtask

  task automatic test_zero();
    logic [511:0] got;
    send('0, '0, '0);
    collect(21, "zero", got);
    checks++;
    if (got[63:0] !== 64'h903df1a0_ade0b876) begin
      errors++;
      $display("FAIL zero_w01 got %h want 903df1a0ade0b876", got[63:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] held, exp;
    int lat = 0;
    out_ready = 0;
    send(rand256(), {$urandom, $urandom, $urandom}, $urandom);
    while (!out_valid && lat < 200) begin tick(); lat++; end
    checks++;
    if (lat !== 21) begin errors++; $display("FAIL bp_latency got %0d want 21", lat); end
    held = keystream;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      key = rand256();
      counter = $urandom;
      tick();
      checks++;
      if (!(out_valid === 1 && in_ready === 0 && keystream === held)) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got ov=%b ir=%b ks=%h want ov=1 ir=0 ks=%h",
                 i, out_valid, in_ready, keystream, held);
      end
    end
    in_valid = 0;
    exp = q.pop_front();
    checks++;
    if (held !== exp) begin errors++; $display("FAIL bp_block got %h want %h", held, exp); end
    out_ready = 1;
    tick();
    checks++;
    if (!(in_ready === 1 && out_valid === 0 && keystream === held)) begin
      errors++;
      $display("FAIL bp_release got ir=%b ov=%b ks=%h want ir=1 ov=0 ks=%h", in_ready, out_valid, keystream, held);
    end
    tick();
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL bp_ignored got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] got;
    send(rand256(), {$urandom, $urandom, $urandom}, $urandom);
    repeat (7) tick();
    rst = 1; tick(); rst = 0;
    q.delete();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || keystream !== '0) begin
      errors++;
      $display("FAIL midreset got ir=%b ov=%b busy=%b ks=%h want 1 0 0 0", in_ready, out_valid, busy, keystream);
    end
    tick();
    checks++;
    if (out_valid !== 0) begin errors++; $display("FAIL midreset_noout got %b want 0", out_valid); end
    send(rand256(), {$urandom, $urandom, $urandom}, $urandom);
    collect(21, "after_reset", got);
  endtask

  task automatic test_back_to_back();
    int n = 0, t1 = 0, t2 = 0;
    logic [511:0] exp;
    key = rand256(); nonce = {$urandom, $urandom, $urandom}; counter = $urandom;
    q.push_back(ref_block(key, nonce, counter, 20));
    q.push_back(ref_block(key, nonce, counter, 20));
    in_valid = 1;
    for (int t = 0; t < 100 && n < 2; t++) begin
      tick();
      if (out_valid) begin
        n++;
        if (n == 1) t1 = t; else begin t2 = t; in_valid = 0; end
        exp = q.pop_front();
        checks++;
        if (keystream !== exp) begin errors++; $display("FAIL b2b_block%0d got %h want %h", n, keystream, exp); end
      end
    end
    in_valid = 0;
    checks++;
    if (n !== 2 || t2 - t1 !== 23) begin
      errors++;
      $display("FAIL b2b_period got blocks=%0d period=%0d want blocks=2 period=23", n, t2 - t1);
    end
    q.delete();
    tick();
  endtask

  task automatic test_rounds8();
    int lat = 0;
    logic [511:0] exp;
    key = rand256(); nonce = {$urandom, $urandom, $urandom}; counter = $urandom;
    q.push_back(ref_block(key, nonce, counter, 8));
    in_valid8 = 1;
    tick();
    in_valid8 = 0;
    while (!out_valid8 && lat < 200) begin tick(); lat++; end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL r8_latency got %0d want 9", lat); end
    exp = q.pop_front();
    checks++;
    if (ks8 !== exp) begin errors++; $display("FAIL r8_block got %h want %h", ks8, exp); end
    tick();
  endtask

`ifdef CHACHA_CTR_AUTOINC_EN
  task automatic test_autoinc();
    logic [255:0] k;
    logic [95:0] n;
    logic [511:0] got;
    k = rand256(); n = {$urandom, $urandom, $urandom};
    next_blk = 1;
    send(k, n, 32'hffffffff);
    q.push_back(ref_block(k, n, 32'h0, 20));
    collect(21, "autoinc_first", got);
    next_blk = 0;
    checks++;
    if (in_ready !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL autoinc_chain got ir=%b busy=%b want ir=0 busy=1", in_ready, busy);
    end
    collect(21, "autoinc_second", got);
  endtask
`endif

  initial begin
    test_reset();
    test_rfc();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_rounds8();
`ifdef CHACHA_CTR_AUTOINC_EN
    test_autoinc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chacha_block_core.md
CHACHA_BLOCK_CORE -- requirements
Module: chacha_block_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 20, meaning the total number of single rounds (column or diagonal); legal values are even numbers 2..20.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the key/nonce/counter request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the core can accept a request.
REQ-006 SHALL have port key, input, 256 bits: key word i = key[32i+31:32i].
REQ-007 SHALL have port nonce, input, 96 bits: nonce word i = nonce[32i+31:32i].
REQ-008 SHALL have port counter, input, 32 bits: the block counter.
REQ-009 SHALL have port out_valid, output, 1 bit: keystream is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the keystream.
REQ-011 SHALL have port keystream, output, 512 bits: state word i = keystream[32i+31:32i].
REQ-012 SHALL have port busy, output, 1 bit: the core is not in IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND, FINAL and DONE.
REQ-014 SHALL assert in_ready only in IDLE; a request is accepted when in_valid and in_ready are both high.
REQ-015 On accept, SHALL load working state and saved state as follows: words 0-3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574; words 4-11 = key; word 12 = counter; words 13-15 = nonce; then SHALL go to ROUND with round count = 0.
REQ-016 In ROUND, SHALL perform one round per cycle using four parallel quarter rounds.
REQ-017 An even round count SHALL select columns (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
REQ-018 An odd round count SHALL select diagonals (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
REQ-019 After round count ROUNDS-1, SHALL go to FINAL.
REQ-020 FINAL SHALL compute keystream word i = working word i + saved word i (mod 2^32, carry discarded), register it, and go to DONE.
REQ-021 DONE SHALL hold out_valid high with keystream stable until out_ready is high, then return to IDLE on the next edge.
REQ-022 Latency from the accept edge to out_valid high SHALL be ROUNDS+1 cycles.
REQ-023 Back-to-back throughput SHALL be one block per ROUNDS+3 cycles when out_ready is held high.
REQ-024 in_valid and key/nonce/counter values SHALL be ignored outside IDLE.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 keystream SHALL hold its last value after handshake until the next FINAL.

Reset
REQ-027 rst SHALL take priority over every other event, including mid-ROUND and during DONE, and SHALL abort any operation in progress without emitting output.
REQ-028 After reset, state SHALL be IDLE, in_ready = 1, out_valid = 0, busy = 0, keystream = 0, round count = 0 and all working/saved words = 0.

Configuration
REQ-029 With macro CHACHA_CTR_AUTOINC_EN defined, SHALL add input port next_blk (1 bit).
REQ-030 With CHACHA_CTR_AUTOINC_EN defined, a DONE handshake with next_blk = 1 SHALL re-enter ROUND directly with saved word 12 + 1 (wrapping 0xFFFFFFFF to 0x00000000) and the same key and nonce, without passing through IDLE.
REQ-031 Without CHACHA_CTR_AUTOINC_EN, port next_blk SHALL not exist and DONE SHALL always return to IDLE.

Structure
REQ-032 Package chacha_pkg SHALL hold the four sigma constants, the state-word-count constant (16), the FSM state enum and a 16x32-bit state array typedef.
REQ-033 SHALL instantiate sub-module chacha_quarterround four times, combinationally, fed from a column/diagonal mux.
REQ-034 SHALL contain no other sub-modules.

Verification
REQ-035 SHALL cover the RFC 8439 2.3.2 vector: key 00..1f, nonce words 0x09000000, 0x4a000000, 0x00000000, counter 1 -> keystream word0 = 0xe4e7f110, word1 = 0x15593bd1, full block matching RFC, out_valid 21 cycles after accept.
REQ-036 SHALL cover all-zero key/nonce/counter -> word0 = 0xade0b876, word1 = 0x903df1a0.
REQ-037 SHALL cover holding out_ready low for 10 cycles -> out_valid stays high, keystream stable, in_ready low, and in_valid pulses are ignored.
REQ-038 SHALL cover asserting rst at round 7 -> next cycle in IDLE, out_valid = 0, keystream = 0; a fresh request then produces the correct block.
REQ-039 With CHACHA_CTR_AUTOINC_EN, SHALL cover counter 0xFFFFFFFF with next_blk = 1 -> second block equals the single-shot block for counter 0x00000000.
REQ-040 SHALL cover ROUNDS = 8 -> block matches the ChaCha8 reference model with latency 9 cycles.
